freq_counter_mc: RTL and testbench

Multi-channel, parametrised frequency counter. It counts rising edges on each of `NUM_CH` asynchronous input signals over a shared gate window of `GATE_CYCLES` clock cycles. At the end of each window it publishes every channel's count together with a one-cycle valid strobe and a per-channel overflow flag. It sits between board-level signal inputs and the display/readout logic, and replaces the single-channel level-sampling counter.

---
 rtl/freq_counter_pkg.sv | 24 ++
 rtl/freq_edge_ch.sv | 70 +++++++
 rtl/freq_counter_mc.sv | 50 +++++
 tb/tb_freq_counter_mc.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/freq_counter_pkg.sv
// Shared defaults and the saturating-increment helper for the multi-channel frequency counter.
// Build option FREQ_SYNC_EN (see freq_edge_ch) selects synchronised edge detection.
package freq_counter_pkg;

  localparam int FC_NUM_CH      = 4;
  localparam int FC_CNT_W       = 16;
  localparam int FC_GATE_CYCLES = 100000000;
  localparam int FC_MAX_W       = 64;

  function automatic logic [FC_MAX_W-1:0] sat_inc(
    input logic [FC_MAX_W-1:0] val,
    input logic                inc,
    input logic                full
  );
    logic [FC_MAX_W-1:0] res;
    if (inc && !full) begin
      res = val + {{(FC_MAX_W-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/freq_edge_ch.sv
// One counter channel: optional 2-flop synchroniser (FREQ_SYNC_EN), rise detect,
// saturating window accumulator with sticky overflow, and the published count latch.
module freq_edge_ch
  import freq_counter_pkg::*;
#(
  parameter int CNT_W = FC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig,
  input  logic             gate_end,
  output logic [CNT_W-1:0] cnt_q,
  output logic             ovf_q
);

  logic d_s;

`ifdef FREQ_SYNC_EN
  logic [1:0] sync_r;

  // two-flop synchroniser; resets high so a level already high is not an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], sig};
    end
  end

  assign d_s = sync_r[1];
`else
  assign d_s = sig;
`endif

  logic             prev_r;
  logic             sat_r;
  logic             rise_s;
  logic             full_s;
  logic             hit_s;
  logic [CNT_W-1:0] acc_r;
  logic [CNT_W-1:0] sum_s;

  assign rise_s = d_s & ~prev_r;
  assign full_s = &acc_r;
  assign hit_s  = full_s & rise_s;
  assign sum_s  = CNT_W'(sat_inc(FC_MAX_W'(acc_r), rise_s, full_s));

  // accumulate within the window; at gate_end publish (edge included) and restart from zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_r <= 1'b1;
      acc_r  <= {CNT_W{1'b0}};
      sat_r  <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
      ovf_q  <= 1'b0;
    end else begin
      prev_r <= d_s;
      if (gate_end) begin
        cnt_q <= sum_s;
        ovf_q <= sat_r | hit_s;
        acc_r <= {CNT_W{1'b0}};
        sat_r <= 1'b0;
      end else begin
        acc_r <= sum_s;
        sat_r <= sat_r | hit_s;
      end
    end
  end

endmodule

// File: rtl/freq_counter_mc.sv
// Multi-channel gated edge counter: one shared gate window, NUM_CH freq_edge_ch instances.
// Define FREQ_SYNC_EN when sigin comes from asynchronous pins.
module freq_counter_mc
  import freq_counter_pkg::*;
#(
  parameter int NUM_CH      = FC_NUM_CH,
  parameter int CNT_W       = FC_CNT_W,
  parameter int GATE_CYCLES = FC_GATE_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       sigin,
  output logic [NUM_CH*CNT_W-1:0] freq,
  output logic                    freq_valid,
  output logic [NUM_CH-1:0]       ovf
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic [GATE_W-1:0] gate_cnt_r;
  logic              gate_end_s;

  assign gate_end_s = (gate_cnt_r == GATE_LAST);

  // gate window counter and the publish strobe that follows its last cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_cnt_r <= {GATE_W{1'b0}};
      freq_valid <= 1'b0;
    end else begin
      gate_cnt_r <= gate_end_s ? {GATE_W{1'b0}} : gate_cnt_r + GATE_W'(1);
      freq_valid <= gate_end_s;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    freq_edge_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig     (sigin[i]),
      .gate_end(gate_end_s),
      .cnt_q   (freq[i*CNT_W +: CNT_W]),
      .ovf_q   (ovf[i])
    );
  end

endmodule

// File: tb/tb_freq_counter_mc.sv
// Scoreboard bench: two counter instances (8-bit/2ch and 3-bit/1ch, 20-cycle gate) driven by
// directed per-cycle patterns; a negedge monitor checks strobe timing, published values and hold.
module tb_freq_counter_mc;

  localparam int G = 20;
`ifdef FREQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic [7:0] f0;
    logic [7:0] f1;
    logic [1:0] ov;
    bit         chk;
  } exp_a_t;

  typedef struct {
    logic [2:0] f;
    logic       ov;
    bit         chk;
  } exp_b_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sa    = 2'b01;
  logic        sb    = 1'b1;
  logic [15:0] freq_a;
  logic        fv_a;
  logic [1:0]  ovf_a;
  logic [2:0]  freq_b;
  logic        fv_b;
  logic        ovf_b;

  exp_a_t qa[$];
  exp_b_t qb[$];
  exp_a_t ea;
  exp_b_t eb;

  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  logic rst_smp = 1'b0;
  logic exp_fv;

  logic [15:0] held_a    = 16'd0;
  logic [1:0]  held_ova  = 2'b00;
  bit          held_a_ok = 1'b0;
  logic [2:0]  held_b    = 3'd0;
  logic        held_ovb  = 1'b0;
  bit          held_b_ok = 1'b0;

  freq_counter_mc #(.NUM_CH(2), .CNT_W(8), .GATE_CYCLES(G)) dut_a (
    .clk(clk), .rst_n(rst_n), .sigin(sa), .freq(freq_a), .freq_valid(fv_a), .ovf(ovf_a)
  );

  freq_counter_mc #(.NUM_CH(1), .CNT_W(3), .GATE_CYCLES(G)) dut_b (
    .clk(clk), .rst_n(rst_n), .sigin(sb), .freq(freq_b), .freq_valid(fv_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  task automatic push_a(input int f0, input int f1, input int ov, input bit chk);
    exp_a_t e;
    e.f0  = 8'(f0);
    e.f1  = 8'(f1);
    e.ov  = 2'(ov);
    e.chk = chk;
    qa.push_back(e);
  endtask

  task automatic push_b(input int f, input int ov, input bit chk);
    exp_b_t e;
    e.f   = 3'(f);
    e.ov  = 1'(ov);
    e.chk = chk;
    qb.push_back(e);
  endtask

  // drive values that the DUT samples at the next rising edge (edge s+1)
  task automatic drive(input int s);
    logic pulse;
    pulse = (s >= 219 - LAT) && (s < 222 - LAT);
    if (s < 50) begin
      sa = 2'b01; sb = 1'b1;
    end else if (s < 110) begin
      sa = {1'b0, 1'(s % 2)}; sb = 1'(s % 2);
    end else if (s < 170) begin
      sa = {1'(( s / 5) % 2), 1'((s / 2) % 2)}; sb = 1'((s / 2) % 2);
    end else if (s < 250) begin
      sa = {1'b0, pulse}; sb = pulse;
    end else begin
      sa = {1'b0, 1'(s % 2)}; sb = 1'(s % 2);
    end
  endtask

  always @(posedge clk) begin
    rst_smp <= rst_n;
    cyc     <= rst_n ? cyc + 1 : 0;
  end

  // monitor: strobe timing, scoreboard pop on strobe, published values held otherwise
  always @(negedge clk) begin
    exp_fv = (cyc != 0) && (cyc % G == 0);
    check("fv_a_timing", 32'(fv_a), 32'(exp_fv));
    check("fv_b_timing", 32'(fv_b), 32'(exp_fv));
    if (!rst_smp) begin
      held_a = 16'd0; held_ova = 2'b00; held_a_ok = 1'b1;
      held_b = 3'd0;  held_ovb = 1'b0;  held_b_ok = 1'b1;
    end
    if (fv_a) begin
      if (qa.size() == 0) begin
        total++; bad++; held_a_ok = 1'b0;
        $display("FAIL qa_underflow: got strobe want none (cyc=%0d)", cyc);
      end else begin
        ea = qa.pop_front();
        held_a_ok = ea.chk;
        if (ea.chk) begin
          check("a_ch0", 32'(freq_a[7:0]), 32'(ea.f0));
          check("a_ch1", 32'(freq_a[15:8]), 32'(ea.f1));
          check("a_ovf", 32'(ovf_a), 32'(ea.ov));
          held_a = {ea.f1, ea.f0}; held_ova = ea.ov;
        end
      end
    end else if (held_a_ok) begin
      check("a_hold", {14'd0, ovf_a, freq_a}, {14'd0, held_ova, held_a});
    end
    if (fv_b) begin
      if (qb.size() == 0) begin
        total++; bad++; held_b_ok = 1'b0;
        $display("FAIL qb_underflow: got strobe want none (cyc=%0d)", cyc);
      end else begin
        eb = qb.pop_front();
        held_b_ok = eb.chk;
        if (eb.chk) begin
          check("b_ch0", 32'(freq_b), 32'(eb.f));
          check("b_ovf", 32'(ovf_b), 32'(eb.ov));
          held_b = eb.f; held_ovb = eb.ov;
        end
      end
    end else if (held_b_ok) begin
      check("b_hold", {28'd0, ovf_b, freq_b}, {28'd0, held_ovb, held_b});
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 345; s++) begin
      // windows 1-2: ch0 high through reset, no false edge
      if (s == 0) begin
        push_a(0, 0, 0, 1'b1); push_a(0, 0, 0, 1'b1);
        push_b(0, 0, 1'b1);    push_b(0, 0, 1'b1);
      end
      // windows 4-5: period 2 -> 10 edges; 3-bit channel saturates
      if (s == 50) begin
        push_a(0, 0, 0, 1'b0); push_a(10, 0, 0, 1'b1); push_a(10, 0, 0, 1'b1);
        push_b(0, 0, 1'b0);    push_b(7, 1, 1'b1);     push_b(7, 1, 1'b1);
      end
      // windows 7-8: period 4 and period 10; overflow clears
      if (s == 110) begin
        push_a(0, 0, 0, 1'b0); push_a(5, 2, 0, 1'b1); push_a(5, 2, 0, 1'b1);
        push_b(0, 0, 1'b0);    push_b(5, 0, 1'b1);    push_b(5, 0, 1'b1);
      end
      if (s == 170) begin
        push_a(0, 0, 0, 1'b0); push_a(0, 0, 0, 1'b1);
        push_b(0, 0, 1'b0);    push_b(0, 0, 1'b1);
      end
      // windows 11-12: single rise landing on the gate_end cycle
      if (s == 190) begin
        push_a(1, 0, 0, 1'b1); push_a(0, 0, 0, 1'b1);
        push_b(1, 0, 1'b1);    push_b(0, 0, 1'b1);
      end
      if (s == 250) begin
        push_a(0, 0, 0, 1'b0); push_a(10, 0, 0, 1'b1);
        push_b(0, 0, 1'b0);    push_b(7, 1, 1'b1);
      end
      // one-cycle reset mid-window discards window 15 and restarts the gate
      if (s == 290) rst_n = 1'b0;
      if (s == 291) begin
        rst_n = 1'b1;
        push_a(0, 0, 0, 1'b0); push_a(10, 0, 0, 1'b1);
        push_b(0, 0, 1'b0);    push_b(7, 1, 1'b1);
      end
      drive(s);
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
